ex: RTL and testbench

EX -- requirements
Module: ex

---
 rtl/ex.sv | 120 ++++++++++++
 tb/tb_ex.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ex.sv
// ex: single-cycle integer execute unit; computes ALU/branch/jump results and
// broadcasts them on the CDB one cycle after issue.
`ifndef OpBus
`define OpBus 5:0
`endif
`ifndef AddrBus
`define AddrBus 31:0
`endif
`ifndef ImmBus
`define ImmBus 31:0
`endif
`ifndef NickBus
`define NickBus 4:0
`endif
`ifndef DataBus
`define DataBus 31:0
`endif

module ex (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            clr,
  input  logic            iRS_en,
  input  logic [`OpBus]   iRS_op,
  input  logic [`AddrBus] iRS_pc,
  input  logic [`ImmBus]  iRS_imm,
  input  logic [`NickBus] iRS_rd_nick,
  input  logic [`DataBus] iRS_rs1_dt,
  input  logic [`DataBus] iRS_rs2_dt,
  output logic            oCDB_en,
  output logic [`NickBus] oCDB_nick,
  output logic [`DataBus] oCDB_dt,
  output logic            oROB_jump,
  output logic [`AddrBus] oROB_pc
);
  localparam logic [`OpBus] OP_LUI = 6'd1, OP_AUIPC = 6'd2, OP_JAL = 6'd3, OP_JALR = 6'd4,
    OP_BEQ = 6'd5, OP_BNE = 6'd6, OP_BLT = 6'd7, OP_BGE = 6'd8, OP_BLTU = 6'd9, OP_BGEU = 6'd10,
    OP_ADDI = 6'd19, OP_SLTI = 6'd20, OP_SLTIU = 6'd21, OP_XORI = 6'd22, OP_ORI = 6'd23,
    OP_ANDI = 6'd24, OP_SLLI = 6'd25, OP_SRLI = 6'd26, OP_SRAI = 6'd27,
    OP_ADD = 6'd28, OP_SUB = 6'd29, OP_SLL = 6'd30, OP_SLT = 6'd31, OP_SLTU = 6'd32,
    OP_XOR = 6'd33, OP_SRL = 6'd34, OP_SRA = 6'd35, OP_OR = 6'd36, OP_AND = 6'd37;

  logic            r_en, r_jump;
  logic [`NickBus] r_nick;
  logic [`DataBus] r_dt;
  logic [`AddrBus] r_pc;
  logic            w_valid, w_jump, w_fire;
  logic [`DataBus] w_a, w_b, w_dt;
  logic [`AddrBus] w_pc4, w_pcimm, w_npc;
  logic [4:0]      w_sh;
  logic            w_lt, w_ltu, w_eq;

  assign w_a     = iRS_rs1_dt;
  assign w_b     = (iRS_op >= OP_ADDI && iRS_op <= OP_SRAI) ? iRS_imm : iRS_rs2_dt;
  assign w_sh    = w_b[4:0];
  assign w_pc4   = iRS_pc + 32'd4;
  assign w_pcimm = iRS_pc + iRS_imm;
  assign w_lt    = $signed(w_a) < $signed(w_b);
  assign w_ltu   = w_a < w_b;
  assign w_eq    = w_a == w_b;
  assign w_fire  = iRS_en && !clr && w_valid;

  always_comb begin
    w_valid = 1'b1;
    w_dt    = '0;
    w_jump  = 1'b0;
    w_npc   = w_pc4;
    case (iRS_op)
      OP_LUI:            w_dt = iRS_imm;
      OP_AUIPC:          w_dt = w_pcimm;
      OP_JAL:            begin w_dt = w_pc4; w_jump = 1'b1; w_npc = w_pcimm; end
      OP_JALR:           begin w_dt = w_pc4; w_jump = 1'b1; w_npc = (w_a + iRS_imm) & ~32'd1; end
      OP_BEQ:            w_jump = w_eq;
      OP_BNE:            w_jump = !w_eq;
      OP_BLT:            w_jump = w_lt;
      OP_BGE:            w_jump = !w_lt;
      OP_BLTU:           w_jump = w_ltu;
      OP_BGEU:           w_jump = !w_ltu;
      OP_ADD, OP_ADDI:   w_dt = w_a + w_b;
      OP_SUB:            w_dt = w_a - w_b;
      OP_AND, OP_ANDI:   w_dt = w_a & w_b;
      OP_OR, OP_ORI:     w_dt = w_a | w_b;
      OP_XOR, OP_XORI:   w_dt = w_a ^ w_b;
      OP_SLL, OP_SLLI:   w_dt = w_a << w_sh;
      OP_SRL, OP_SRLI:   w_dt = w_a >> w_sh;
      OP_SRA, OP_SRAI:   w_dt = $signed(w_a) >>> w_sh;
      OP_SLT, OP_SLTI:   w_dt = {31'd0, w_lt};
      OP_SLTU, OP_SLTIU: w_dt = {31'd0, w_ltu};
      default:           w_valid = 1'b0;
    endcase
    if (iRS_op >= OP_BEQ && iRS_op <= OP_BGEU)
      w_npc = w_jump ? w_pcimm : w_pc4;
  end

  // a stalled cycle (rdy=0) holds everything, including a pending oCDB_en=1
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_en   <= 1'b0;
      r_nick <= '0;
      r_dt   <= '0;
      r_jump <= 1'b0;
      r_pc   <= '0;
    end else if (rdy) begin
      r_en <= w_fire;
      if (w_fire) begin
        r_nick <= iRS_rd_nick;
        r_dt   <= w_dt;
        r_jump <= w_jump;
        r_pc   <= w_npc;
      end
    end
  end

  assign oCDB_en   = r_en;
  assign oCDB_nick = r_nick;
  assign oCDB_dt   = r_dt;
  assign oROB_jump = r_jump;
  assign oROB_pc   = r_pc;
endmodule

// File: tb/tb_ex.sv
// tb_ex: directed vectors for ex, checked every cycle against a behavioural
// model plus hand-computed literal expectations.
module tb_ex;
  localparam logic [5:0] LUI = 1, AUIPC = 2, JAL = 3, JALR = 4, BEQ = 5, BNE = 6, BLT = 7,
    BGE = 8, BLTU = 9, BGEU = 10, LW = 13, SW = 18, ADDI = 19, SLTI = 20, SLTIU = 21,
    XORI = 22, ORI = 23, ANDI = 24, SLLI = 25, SRLI = 26, SRAI = 27, ADD = 28, SUB = 29,
    SLL = 30, SLT = 31, SLTU = 32, XOR = 33, SRL = 34, SRA = 35, OR = 36, AND = 37;

  logic clk = 0, rst = 0, rdy = 0, clr = 0, en = 0;
  logic [5:0] op = 0;
  logic [31:0] pc = 0, imm = 0, a = 0, b = 0;
  logic [4:0] nick = 0;
  logic cdb_en, jump;
  logic [4:0] cdb_nick;
  logic [31:0] cdb_dt, rob_pc;
  int tests = 0, fails = 0;

  bit m_live = 0, m_en = 0, m_jump = 0;
  logic [4:0] m_nick = 0;
  logic [31:0] m_dt = 0, m_pc = 0;

  ex dut (.clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .iRS_en(en), .iRS_op(op),
    .iRS_pc(pc), .iRS_imm(imm), .iRS_rd_nick(nick), .iRS_rs1_dt(a), .iRS_rs2_dt(b),
    .oCDB_en(cdb_en), .oCDB_nick(cdb_nick), .oCDB_dt(cdb_dt), .oROB_jump(jump),
    .oROB_pc(rob_pc));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic golden(input logic [5:0] o, input logic [31:0] p, i, x, y,
                        output bit ok, output logic [31:0] d, output bit j,
                        output logic [31:0] np);
    int signed sx, sy;
    logic [31:0] yy;
    yy = (o >= ADDI && o <= SRAI) ? i : y;
    sx = x; sy = yy;
    ok = 1; d = 0; j = 0; np = p + 4;
    case (o)
      LUI: d = i;
      AUIPC: d = p + i;
      JAL: begin d = p + 4; j = 1; np = p + i; end
      JALR: begin d = p + 4; j = 1; np = (x + i) & 32'hFFFF_FFFE; end
      BEQ: j = (x == y);
      BNE: j = (x != y);
      BLT: j = (sx < sy);
      BGE: j = (sx >= sy);
      BLTU: j = (x < y);
      BGEU: j = (x >= y);
      ADD, ADDI: d = x + yy;
      SUB: d = x - yy;
      AND, ANDI: d = x & yy;
      OR, ORI: d = x | yy;
      XOR, XORI: d = x ^ yy;
      SLL, SLLI: d = x << (yy % 32);
      SRL, SRLI: d = x >> (yy % 32);
      SRA, SRAI: d = sx >>> (yy % 32);
      SLT, SLTI: d = (sx < sy) ? 1 : 0;
      SLTU, SLTIU: d = (x < yy) ? 1 : 0;
      default: ok = 0;
    endcase
    if (o >= BEQ && o <= BGEU) np = j ? p + i : p + 4;
  endtask

  always @(posedge clk) begin
    bit ok, j;
    logic [31:0] d, np;
    golden(op, pc, imm, a, b, ok, d, j, np);
    if (!rst) begin
      m_live = 1; m_en = 0; m_nick = 0; m_dt = 0; m_jump = 0; m_pc = 0;
    end else if (rdy) begin
      m_en = en && !clr && ok;
      if (m_en) begin m_nick = nick; m_dt = d; m_jump = j; m_pc = np; end
    end
  end

  always @(negedge clk) if (m_live) begin
    check("cmp_en", {31'd0, cdb_en}, {31'd0, m_en});
    check("cmp_nick", {27'd0, cdb_nick}, {27'd0, m_nick});
    check("cmp_dt", cdb_dt, m_dt);
    check("cmp_jump", {31'd0, jump}, {31'd0, m_jump});
    check("cmp_pc", rob_pc, m_pc);
  end

  task automatic step(input logic e, input logic [5:0] o, input logic [31:0] p, i, x, y,
                      input logic [4:0] n);
    en = e; op = o; pc = p; imm = i; a = x; b = y; nick = n;
    @(negedge clk);
  endtask

  task automatic pin(input string name, input logic e, input logic [4:0] n,
                     input logic [31:0] d, input logic j, input logic [31:0] p);
    check({name, "_en"}, {31'd0, cdb_en}, {31'd0, e});
    check({name, "_nick"}, {27'd0, cdb_nick}, {27'd0, n});
    check({name, "_dt"}, cdb_dt, d);
    check({name, "_jump"}, {31'd0, jump}, {31'd0, j});
    check({name, "_pc"}, rob_pc, p);
  endtask

  initial begin
    @(negedge clk);
    step(1, ADD, 32'h10, 0, 5, 6, 7);
    step(1, ADD, 32'h10, 0, 5, 6, 7);
    pin("reset", 0, 0, 0, 0, 0);
    rst = 1; rdy = 1;
    step(1, ADDI, 32'h200, 1, 32'hFFFF_FFFF, 0, 3);
    pin("addi", 1, 3, 0, 0, 32'h204);
    step(1, SRA, 32'h300, 0, 32'h8000_0000, 32'h24, 4);
    pin("sra", 1, 4, 32'hF800_0000, 0, 32'h304);
    step(1, SLTU, 32'h304, 0, 1, 32'hFFFF_FFFF, 5);
    pin("sltu", 1, 5, 1, 0, 32'h308);
    step(1, BLT, 32'h100, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 0, 6);
    pin("blt", 1, 6, 0, 1, 32'hF8);
    step(1, BGEU, 32'h100, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 0, 7);
    pin("bgeu", 1, 7, 0, 1, 32'hF8);
    step(1, BLTU, 32'h100, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 0, 8);
    pin("bltu", 1, 8, 0, 0, 32'h104);
    step(1, JALR, 32'h40, 2, 32'h1001, 0, 9);
    pin("jalr", 1, 9, 32'h44, 1, 32'h1002);
    step(1, JAL, 32'h500, 32'hFFFF_FF00, 0, 0, 1);
    step(1, LUI, 32'h0, 32'hABCD_E000, 0, 0, 2);
    step(1, AUIPC, 32'h1000, 32'h0000_3000, 0, 0, 3);
    step(1, SUB, 32'h8, 0, 0, 1, 4);
    pin("sub", 1, 4, 32'hFFFF_FFFF, 0, 32'hC);
    step(1, AND, 32'h8, 0, 32'hF0F0_1234, 32'h0FF0_FFFF, 5);
    step(1, OR, 32'h8, 0, 32'hF000_0000, 32'h0000_000F, 6);
    step(1, XOR, 32'h8, 0, 32'hAAAA_AAAA, 32'hFFFF_0000, 7);
    step(1, XORI, 32'h8, 32'hFFFF_FFFF, 32'h1234_5678, 0, 8);
    step(1, ORI, 32'h8, 32'h0000_0100, 32'h1, 0, 9);
    step(1, ANDI, 32'h8, 32'h0000_00FF, 32'h1234_5678, 0, 10);
    step(1, SLL, 32'h8, 0, 32'h1, 32'hFFFF_FFE1, 11);
    pin("sll", 1, 11, 32'h2, 0, 32'hC);
    step(1, SRL, 32'h8, 0, 32'h8000_0000, 32'h1F, 12);
    step(1, SLLI, 32'h8, 32'h4, 32'h0000_00FF, 0, 13);
    step(1, SRLI, 32'h8, 32'h8, 32'hFF00_0000, 0, 14);
    step(1, SRAI, 32'h8, 32'h8, 32'hFF00_0000, 0, 15);
    step(1, SLT, 32'h8, 0, 32'hFFFF_FFFF, 1, 16);
    step(1, SLTI, 32'h8, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 17);
    step(1, SLTIU, 32'h8, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 18);
    step(1, BEQ, 32'h20, 32'h40, 9, 9, 19);
    step(1, BNE, 32'h20, 32'h40, 9, 9, 20);
    step(1, BGE, 32'h20, 32'h40, 0, 32'hFFFF_FFFF, 21);
    pin("bge", 1, 21, 0, 1, 32'h60);
    step(0, ADD, 32'h70, 0, 1, 1, 22);
    pin("idle", 0, 21, 0, 1, 32'h60);
    step(1, LW, 32'h70, 0, 1, 1, 23);
    pin("lw", 0, 21, 0, 1, 32'h60);
    step(1, SW, 32'h70, 0, 1, 1, 24);
    step(1, ADD, 32'h80, 0, 1, 2, 10);
    pin("b2b_a", 1, 10, 3, 0, 32'h84);
    step(1, SUB, 32'h84, 0, 9, 4, 11);
    pin("b2b_b", 1, 11, 5, 0, 32'h88);
    rdy = 0;
    step(1, XOR, 32'h88, 0, 6, 3, 12);
    pin("b2b_stall", 1, 11, 5, 0, 32'h88);
    rdy = 1;
    step(1, XOR, 32'h88, 0, 6, 3, 12);
    pin("b2b_c", 1, 12, 5, 0, 32'h8C);
    step(1, OR, 32'h8C, 0, 8, 1, 13);
    pin("b2b_d", 1, 13, 9, 0, 32'h90);
    clr = 1;
    step(1, ADD, 32'h90, 0, 7, 7, 14);
    pin("clr", 0, 13, 9, 0, 32'h90);
    clr = 0;
    rdy = 0;
    step(1, ADD, 32'h90, 0, 7, 7, 14);
    pin("stall_idle", 0, 13, 9, 0, 32'h90);
    rst = 0;
    step(1, ADD, 32'h90, 0, 7, 7, 14);
    pin("rst2", 0, 0, 0, 0, 0);
    rst = 1; rdy = 1;
    step(0, ADD, 0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
